dsp38_inst_design: RTL and testbench



---
 rtl/dsp38_inst_design.sv | 54 +++++
 tb/tb_dsp38_inst_design.sv | 118 +++++++++++
 2 files changed

// File: rtl/dsp38_inst_design.sv
// Unsigned 20x18 multiply-accumulate with a 38-bit wrap-around accumulator.
// z_out registers (acc + a*b) & (a*b) every clock.
module dsp38_inst_design #(
  parameter int unsigned A_WIDTH = 20,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned Z_WIDTH = 38
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [Z_WIDTH-1:0] z_out
);

  logic [Z_WIDTH-1:0] prod;
  logic [Z_WIDTH-1:0] acc_d, acc_q;
  logic [Z_WIDTH-1:0] z_d, z_q;
  logic               rst_sync_d, rst_sync_q;

  // Reset asserts asynchronously but releases on a clock edge, so the first
  // accumulate lands on the first full edge after release.
  assign rst_sync_d = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_sync_q <= 1'b1;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  always_comb begin
    prod  = Z_WIDTH'(a) * Z_WIDTH'(b);
    acc_d = acc_q;
    z_d   = z_q;
    if (!rst_sync_q) begin
      acc_d = acc_q + prod;
      z_d   = acc_d & prod;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      z_q   <= '0;
    end else begin
      acc_q <= acc_d;
      z_q   <= z_d;
    end
  end

  assign z_out = z_q;

endmodule

// File: tb/tb_dsp38_inst_design.sv
// Directed and random checks of dsp38_inst_design against a small MAC model.
module tb_dsp38_inst_design;

  logic        clk;
  logic        reset;
  logic [19:0] a;
  logic [17:0] b;
  logic [37:0] z_out;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [37:0] acc_m;

  localparam logic [19:0] AMax = 20'h7FFFF;
  localparam logic [17:0] BMax = 18'h1FFFF;

  dsp38_inst_design u_dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .z_out (z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [37:0] got, input logic [37:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%010h expected 0x%010h", tag, got, exp);
    end
  endtask

  // One accumulate edge; model tracks acc, z_out is compared to exp_z.
  task automatic step(input logic [19:0] ai, input logic [17:0] bi, input string tag,
                      input logic [37:0] exp_z);
    @(negedge clk);
    a = ai;
    b = bi;
    @(posedge clk);
    #1;
    check_eq(tag, z_out, exp_z);
  endtask

  task automatic step_model(input logic [19:0] ai, input logic [17:0] bi, input string tag);
    logic [37:0] p;
    p     = {18'b0, ai} * {20'b0, bi};
    acc_m = acc_m + p;
    step(ai, bi, tag, acc_m & p);
  endtask

  // Release reset with zero inputs; extra zero edges leave acc at 0.
  task automatic release_reset();
    @(negedge clk);
    a     = '0;
    b     = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post_release_zero", z_out, 38'h0);
    acc_m = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    acc_m    = '0;
    reset    = 1'b1;
    a        = '0;
    b        = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_z", z_out, 38'h0);
    // Nonzero inputs must not move state while reset is held.
    a = AMax;
    b = BMax;
    @(posedge clk);
    #1;
    check_eq("reset_hold", z_out, 38'h0);
    release_reset();

    step(AMax, BMax, "max_1", 38'h0FFFF60001);
    step(AMax, BMax, "max_2", 38'h0FFFE40000);
    step(20'h0, 18'h5, "zero_in", 38'h0);
    // acc still 2p, so the next edges give 3p, 4p, then wrap at 5p.
    step(AMax, BMax, "max_3", 38'h0FFFE20001);
    step(AMax, BMax, "max_4", 38'h0FFFD00000);
    step(AMax, BMax, "wrap_5", 38'h0FFFC60001);
    acc_m = 38'h0FFFCE0005;
    step_model(20'h1, 18'h1, "after_wrap");
    step_model(20'h3, 18'h3, "small");

    for (int i = 0; i < 600; i++) begin
      step_model(20'($urandom), 18'($urandom), "random");
    end

    // Asynchronous reset between edges clears z_out without a clock.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_z", z_out, 38'h0);
    @(posedge clk);
    #1;
    check_eq("async_reset_hold", z_out, 38'h0);
    release_reset();
    step(AMax, BMax, "restart_max", 38'h0FFFF60001);
    acc_m = 38'h0FFFF60001;
    step_model(AMax, BMax, "restart_max_2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
